// File: rtl/radar_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : radar_sched_pkg
// Description : Shared types and constants for the radar time-share
//               scheduler: FSM state encoding, distance width and
//               saturation value, plus the distance saturation helper.
//               Also used by the tracking and weapon control units.
// Revision    : 1.0 - initial release
// ============================================================================
package radar_sched_pkg;

  // Scheduler FSM states, explicit 3-bit encoding.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_TRIGGER = 3'd1,
    ST_LISTEN  = 3'd2,
    ST_REPORT  = 3'd3,
    ST_GUARD   = 3'd4
  } sched_state_e;

  localparam int              DIST_W   = 14;
  localparam logic [13:0]     DIST_MAX = 14'h3FFF;
  localparam int              PROD_W   = 22;   // width of count * metres-per-cycle
  localparam int              CNT_W    = 8;    // LISTEN counter, covers 1..255
  localparam int              GUARD_W  = 4;    // guard counter, covers 0..15

  // Clamp a raw product onto the 14-bit distance range.
  function automatic logic [DIST_W-1:0] sat_dist(input logic [PROD_W-1:0] prod);
    if (prod > PROD_W'(DIST_MAX)) begin
      return DIST_MAX;
    end
    return prod[DIST_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/radar_time_share_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : radar_time_share_scheduler_if
// Description : Bundle between the tracking requesters / radar front end and
//               the time-share scheduler.
//   req                        requester ping requests (level)
//   grant                      one-hot owner of the current transaction
//   trigger_radar_transmitter  one-cycle transmit pulse
//   radar_echo                 single-cycle echo pulse from the receiver
//   result_valid               one-cycle result strobe
//   result_id                  requester index the result belongs to
//   result_hit                 1 = echo received, 0 = timeout
//   distance_to_target         metres, 0 on timeout
//   busy                       scheduler not idle
//   master : scheduler side      slave : requesters / front-end side
// Revision    : 1.0 - initial release
// ============================================================================
interface radar_time_share_scheduler_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
);
  import radar_sched_pkg::*;

  logic [N_REQ-1:0]  req;
  logic [N_REQ-1:0]  grant;
  logic              trigger_radar_transmitter;
  logic              radar_echo;
  logic              result_valid;
  logic [ID_W-1:0]   result_id;
  logic              result_hit;
  logic [DIST_W-1:0] distance_to_target;
  logic              busy;

  modport master (
    input  req,
    input  radar_echo,
    output grant,
    output trigger_radar_transmitter,
    output result_valid,
    output result_id,
    output result_hit,
    output distance_to_target,
    output busy
  );

  modport slave (
    output req,
    output radar_echo,
    input  grant,
    input  trigger_radar_transmitter,
    input  result_valid,
    input  result_id,
    input  result_hit,
    input  distance_to_target,
    input  busy
  );

endinterface
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin picker. Scans requests starting at
//               index ptr (wrapping) and returns the first set one.
//   req    in   N_REQ  request vector
//   ptr    in   ID_W   index with highest priority this round
//   grant  out  N_REQ  one-hot winner, 0 when no request
//   winner out  ID_W   winner index
//   valid  out  1      at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  wire logic [N_REQ-1:0] req,
  input  wire logic [ID_W-1:0]  ptr,
  output logic      [N_REQ-1:0] grant,
  output logic      [ID_W-1:0]  winner,
  output logic                  valid
);

  int idx;

  always_comb begin
    grant  = '0;
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(ptr) + i) % N_REQ;
      if (!valid && req[idx]) begin
        valid      = 1'b1;
        winner     = ID_W'(idx);
        grant[idx] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/radar_time_share_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : radar_time_share_scheduler
// Description : Shares one radar transmitter/receiver between N_REQ tracking
//               requesters. Grants one requester (round-robin), fires a
//               single transmit pulse, times the echo and reports a tagged
//               distance or timeout result.
//   clk   in   system clock
//   rst   in   synchronous active-high reset
//   bus   master modport of radar_time_share_scheduler_if (req/grant,
//         trigger/echo, result_valid/id/hit/distance, busy)
// Revision    : 1.0 - initial release
// ============================================================================
module radar_time_share_scheduler
  import radar_sched_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int LISTEN_CYCLES  = 10,
  parameter int DIST_PER_CYCLE = 1500,
  parameter int GUARD_CYCLES   = 1
) (
  input wire logic                       clk,
  input wire logic                       rst,
  radar_time_share_scheduler_if.master   bus
);

  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  sched_state_e      state_q, state_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic              trigger_q, trigger_d;
  logic              result_valid_q, result_valid_d;
  logic [ID_W-1:0]   result_id_q, result_id_d;
  logic              result_hit_q, result_hit_d;
  logic [DIST_W-1:0] dist_q, dist_d;
  logic              busy_q, busy_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   owner_q, owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [GUARD_W-1:0] guard_q, guard_d;

  logic [N_REQ-1:0]  arb_grant;
  logic [ID_W-1:0]   arb_winner;
  logic              arb_valid;
  logic [CNT_W-1:0]  cnt_next;
  logic [PROD_W-1:0] prod;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req    (bus.req),
    .ptr    (rr_ptr_q),
    .grant  (arb_grant),
    .winner (arb_winner),
    .valid  (arb_valid)
  );

  // cnt_next is the count belonging to the current LISTEN cycle (1 on the
  // first one), so an echo sampled now is timed with it directly.
  assign cnt_next = cnt_q + CNT_W'(1);
  assign prod     = PROD_W'(cnt_next) * PROD_W'(DIST_PER_CYCLE);

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    trigger_d      = 1'b0;
    result_valid_d = 1'b0;
    result_id_d    = result_id_q;
    result_hit_d   = result_hit_q;
    dist_d         = dist_q;
    rr_ptr_d       = rr_ptr_q;
    owner_d        = owner_q;
    cnt_d          = cnt_q;
    guard_d        = guard_q;

    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          state_d   = ST_TRIGGER;
          grant_d   = arb_grant;
          owner_d   = arb_winner;
          trigger_d = 1'b1;
          cnt_d     = '0;
          rr_ptr_d  = (arb_winner == ID_W'(N_REQ - 1)) ? '0 : arb_winner + ID_W'(1);
        end
      end

      ST_TRIGGER: begin
        state_d = ST_LISTEN;
        cnt_d   = '0;
      end

      ST_LISTEN: begin
        cnt_d = cnt_next;
        // Echo is checked first so a hit on the timeout cycle still counts.
        if (bus.radar_echo) begin
          state_d        = ST_REPORT;
          result_valid_d = 1'b1;
          result_id_d    = owner_q;
          result_hit_d   = 1'b1;
          dist_d         = sat_dist(prod);
        end else if (cnt_next == CNT_W'(LISTEN_CYCLES)) begin
          state_d        = ST_REPORT;
          result_valid_d = 1'b1;
          result_id_d    = owner_q;
          result_hit_d   = 1'b0;
          dist_d         = '0;
        end
      end

      ST_REPORT: begin
        grant_d = '0;
        if (GUARD_CYCLES == 0) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_GUARD;
          guard_d = '0;
        end
      end

      ST_GUARD: begin
        if (guard_q == GUARD_W'(GUARD_CYCLES - 1)) begin
          state_d = ST_IDLE;
        end else begin
          guard_d = guard_q + GUARD_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      grant_q        <= '0;
      trigger_q      <= 1'b0;
      result_valid_q <= 1'b0;
      result_id_q    <= '0;
      result_hit_q   <= 1'b0;
      dist_q         <= '0;
      busy_q         <= 1'b0;
      rr_ptr_q       <= '0;
      owner_q        <= '0;
      cnt_q          <= '0;
      guard_q        <= '0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      trigger_q      <= trigger_d;
      result_valid_q <= result_valid_d;
      result_id_q    <= result_id_d;
      result_hit_q   <= result_hit_d;
      dist_q         <= dist_d;
      busy_q         <= busy_d;
      rr_ptr_q       <= rr_ptr_d;
      owner_q        <= owner_d;
      cnt_q          <= cnt_d;
      guard_q        <= guard_d;
    end
  end

  assign bus.grant                     = grant_q;
  assign bus.trigger_radar_transmitter = trigger_q;
  assign bus.result_valid              = result_valid_q;
  assign bus.result_id                 = result_id_q;
  assign bus.result_hit                = result_hit_q;
  assign bus.distance_to_target        = dist_q;
  assign bus.busy                      = busy_q;

endmodule
`default_nettype wire
